mem_port_arbiter: RTL and testbench

- Two-requester controller in front of the 256-line x 128-bit data memory.
- Port 0 is a read-only line-refill port (instruction side). Port 1 is a read/word-write port (load/store side).
- Arbitrates round-robin, serialises one memory operation at a time, and issues single-cycle read/write request pulses.
- Counts a fixed memory latency and returns the line with a one-cycle done pulse to the granted requester.

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for two requesters sharing the 256x128 data memory.
// Serialises one memory operation at a time and times completion with a fixed-latency counter.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_done,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [1:0]        p1_word_id,
    input  logic [WORD_W-1:0] p1_wdata,
    output logic              p1_done,
    output logic [LINE_W-1:0] resp_rdata,
    output logic              busy,
    output logic              mem_r_req_out,
    output logic              mem_w_req_out,
    output logic              mem_wr_en_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [1:0]        mem_word_id_out,
    output logic [WORD_W-1:0] mem_wr_data_out,
    input  logic [LINE_W-1:0] mem_rdata_in
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state, state_next;
    logic               last_gnt, last_gnt_next;
    logic               gnt, gnt_next;
    logic               we, we_next;
    logic [CNT_W-1:0]   cnt, cnt_next;

    logic               p0_done_next, p1_done_next, busy_next;
    logic               mem_r_req_next, mem_w_req_next, mem_wr_en_next;
    logic [ADDR_W-1:0]  mem_addr_next;
    logic [1:0]         mem_word_id_next;
    logic [WORD_W-1:0]  mem_wr_data_next;
    logic [LINE_W-1:0]  resp_rdata_next;

    logic               any_req;
    logic               gnt_sel;
    logic               we_sel;

    // On a tie the port that did not win last time is granted
    assign any_req = p0_req | p1_req;
    assign gnt_sel = (p0_req && p1_req) ? ~last_gnt : p1_req;
    assign we_sel  = gnt_sel & p1_we;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            last_gnt        <= 1'b1;
            gnt             <= 1'b0;
            we              <= 1'b0;
            cnt             <= '0;
            p0_done         <= 1'b0;
            p1_done         <= 1'b0;
            busy            <= 1'b0;
            mem_r_req_out   <= 1'b0;
            mem_w_req_out   <= 1'b0;
            mem_wr_en_out   <= 1'b0;
            mem_addr_out    <= '0;
            mem_word_id_out <= '0;
            mem_wr_data_out <= '0;
            resp_rdata      <= '0;
        end else begin
            state           <= state_next;
            last_gnt        <= last_gnt_next;
            gnt             <= gnt_next;
            we              <= we_next;
            cnt             <= cnt_next;
            p0_done         <= p0_done_next;
            p1_done         <= p1_done_next;
            busy            <= busy_next;
            mem_r_req_out   <= mem_r_req_next;
            mem_w_req_out   <= mem_w_req_next;
            mem_wr_en_out   <= mem_wr_en_next;
            mem_addr_out    <= mem_addr_next;
            mem_word_id_out <= mem_word_id_next;
            mem_wr_data_out <= mem_wr_data_next;
            resp_rdata      <= resp_rdata_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (any_req) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (cnt == CNT_W'(1)) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output and datapath next values; memory payload is latched at grant so it is live in ISSUE
    always_comb begin
        last_gnt_next    = last_gnt;
        gnt_next         = gnt;
        we_next          = we;
        cnt_next         = cnt;
        p0_done_next     = 1'b0;
        p1_done_next     = 1'b0;
        busy_next        = (state_next != IDLE);
        mem_r_req_next   = 1'b0;
        mem_w_req_next   = 1'b0;
        mem_wr_en_next   = mem_wr_en_out;
        mem_addr_next    = mem_addr_out;
        mem_word_id_next = mem_word_id_out;
        mem_wr_data_next = mem_wr_data_out;
        resp_rdata_next  = resp_rdata;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_next         = gnt_sel;
                    last_gnt_next    = gnt_sel;
                    we_next          = we_sel;
                    mem_r_req_next   = ~we_sel;
                    mem_w_req_next   = we_sel;
                    mem_wr_en_next   = we_sel;
                    mem_addr_next    = gnt_sel ? p1_addr : p0_addr;
                    mem_word_id_next = gnt_sel ? p1_word_id : 2'd0;
                    mem_wr_data_next = gnt_sel ? p1_wdata : '0;
                end
            end
            ISSUE: cnt_next = CNT_W'(MEM_LAT);
            WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    resp_rdata_next = we ? '0 : mem_rdata_in;
                    p0_done_next    = ~gnt;
                    p1_done_next    = gnt;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LAT=1 main instance plus a MEM_LAT=3 instance.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned LW = 128;
    localparam int unsigned WW = 32;

    typedef struct {logic port; logic [LW-1:0] rdata;} done_t;
    typedef struct {logic we; logic [AW-1:0] addr; logic [1:0] wid; logic [WW-1:0] wdata;} memx_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic p0_req, p1_req, p1_we, p0_done, p1_done, busy;
    logic [AW-1:0] p0_addr, p1_addr, mem_addr;
    logic [1:0] p1_word_id, mem_wid;
    logic [WW-1:0] p1_wdata, mem_wdata;
    logic [LW-1:0] resp_rdata, mem_rdata;
    logic mem_r_req, mem_w_req, mem_wr_en;

    logic p1_req3, p0_done3, p1_done3, busy3, mem_r_req3, mem_w_req3, mem_wr_en3;
    logic [AW-1:0] p1_addr3, mem_addr3;
    logic [1:0] mem_wid3;
    logic [WW-1:0] mem_wdata3;
    logic [LW-1:0] resp_rdata3, mem_rdata3;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int age1 = 0;
    int age3 = 0;
    int last_req_cyc = 0;
    logic prev_done = 1'b0;
    done_t dq[$];
    memx_t mq[$];

    mem_port_arbiter #(.MEM_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_word_id(p1_word_id),
        .p1_wdata(p1_wdata), .p1_done(p1_done), .resp_rdata(resp_rdata), .busy(busy),
        .mem_r_req_out(mem_r_req), .mem_w_req_out(mem_w_req), .mem_wr_en_out(mem_wr_en),
        .mem_addr_out(mem_addr), .mem_word_id_out(mem_wid), .mem_wr_data_out(mem_wdata),
        .mem_rdata_in(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .p0_req(1'b0), .p0_addr(8'h00), .p0_done(p0_done3),
        .p1_req(p1_req3), .p1_we(1'b0), .p1_addr(p1_addr3), .p1_word_id(2'd0),
        .p1_wdata(32'h0), .p1_done(p1_done3), .resp_rdata(resp_rdata3), .busy(busy3),
        .mem_r_req_out(mem_r_req3), .mem_w_req_out(mem_w_req3), .mem_wr_en_out(mem_wr_en3),
        .mem_addr_out(mem_addr3), .mem_word_id_out(mem_wid3), .mem_wr_data_out(mem_wdata3),
        .mem_rdata_in(mem_rdata3)
    );

    function automatic logic [LW-1:0] line_for(input logic [AW-1:0] a);
        if (a == 8'h3C) return 128'hDEAD_BEEF_0000_0001_CAFE_F00D_1234_5678;
        return {16{a}} ^ 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
    endfunction

    // Memory models: data is valid only exactly MEM_LAT cycles after the request pulse
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) age1 <= 0;
        else if (mem_r_req || mem_w_req) age1 <= 1;
        else if (age1 < 100) age1 <= age1 + 1;
        if (reset) age3 <= 0;
        else if (mem_r_req3 || mem_w_req3) age3 <= 1;
        else if (age3 < 100) age3 <= age3 + 1;
    end
    assign mem_rdata  = (age1 == 1) ? line_for(mem_addr)  : {LW{1'b1}};
    assign mem_rdata3 = (age3 == 3) ? line_for(mem_addr3) : {LW{1'b1}};

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not as required", name);
    endtask

    // Monitor: pops expected memory requests and completions as the DUT presents them
    always @(negedge clk) begin
        if (prev_done) chk("busy_idle_gap", LW'(busy), LW'(0));
        if (mem_r_req || mem_w_req) begin
            chk("rw_exclusive", LW'(mem_r_req & mem_w_req), LW'(0));
            chk("busy_in_issue", LW'(busy), LW'(1));
            if (mq.size() == 0) fail("unexpected_mem_req");
            else begin
                memx_t m;
                m = mq.pop_front();
                chk("mem_we", LW'(mem_w_req), LW'(m.we));
                chk("mem_wr_en", LW'(mem_wr_en), LW'(m.we));
                chk("mem_addr", LW'(mem_addr), LW'(m.addr));
                if (m.we) begin
                    chk("mem_word_id", LW'(mem_wid), LW'(m.wid));
                    chk("mem_wdata", LW'(mem_wdata), LW'(m.wdata));
                end
            end
            last_req_cyc = cyc;
        end
        if (p0_done || p1_done) begin
            chk("done_exclusive", LW'(p0_done & p1_done), LW'(0));
            chk("busy_in_done", LW'(busy), LW'(1));
            if (dq.size() == 0) fail("unexpected_done");
            else begin
                done_t d;
                d = dq.pop_front();
                chk("done_port", LW'(p1_done), LW'(d.port));
                chk("resp_rdata", resp_rdata, d.rdata);
                chk("done_latency", LW'(cyc - last_req_cyc), LW'(2));
            end
        end
        prev_done = p0_done | p1_done;
    end

    // which: 0 = port 0, 1 = port 1, 2 = either
    task automatic wait_done(input int which, output int at);
        at = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if ((which != 1 && p0_done === 1'b1) || (which != 0 && p1_done === 1'b1)) begin
                at = cyc;
                return;
            end
        end
        fail("done_timeout");
    endtask

    function automatic memx_t mx(input logic we, input logic [AW-1:0] a, input logic [1:0] w,
                                 input logic [WW-1:0] d);
        memx_t m;
        m.we = we; m.addr = a; m.wid = w; m.wdata = d;
        return m;
    endfunction

    function automatic done_t dx(input logic port, input logic [LW-1:0] r);
        done_t d;
        d.port = port; d.rdata = r;
        return d;
    endfunction

    initial begin
        int t[4];
        int tmp;
        int rc, dc, nreq;
        reset = 1'b1;
        p0_req = 0; p1_req = 0; p1_we = 0; p0_addr = '0; p1_addr = '0;
        p1_word_id = '0; p1_wdata = '0; p1_req3 = 0; p1_addr3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", LW'({p0_done, p1_done, busy, mem_r_req, mem_w_req, mem_wr_en,
                                  mem_addr, mem_wid, mem_wdata}), LW'(0));
        chk("reset_rdata", resp_rdata, LW'(0));
        reset = 1'b0;

        // Round robin from reset: both held high, order 0,1,0,1
        p0_addr = 8'h11; p1_addr = 8'h22; p1_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic pp;
            pp = (i % 2 == 1);
            mq.push_back(mx(1'b0, pp ? 8'h22 : 8'h11, 2'd0, 32'h0));
            dq.push_back(dx(pp, line_for(pp ? 8'h22 : 8'h11)));
        end
        p0_req = 1; p1_req = 1;
        for (int i = 0; i < 4; i++) wait_done(2, t[i]);
        p0_req = 0; p1_req = 0;
        for (int i = 1; i < 4; i++) chk("rr_spacing", LW'(t[i] - t[i-1]), LW'(4));

        // Single port 0 read
        @(negedge clk);
        p0_addr = 8'h3C;
        mq.push_back(mx(1'b0, 8'h3C, 2'd0, 32'h0));
        dq.push_back(dx(1'b0, 128'hDEAD_BEEF_0000_0001_CAFE_F00D_1234_5678));
        p0_req = 1;
        wait_done(0, tmp);
        p0_req = 0;

        // Port 1 word write returns a zero line
        @(negedge clk);
        p1_we = 1; p1_addr = 8'h05; p1_word_id = 2'd2; p1_wdata = 32'hA5A5_0F0F;
        mq.push_back(mx(1'b1, 8'h05, 2'd2, 32'hA5A5_0F0F));
        dq.push_back(dx(1'b1, '0));
        p1_req = 1;
        wait_done(1, tmp);
        p1_req = 0;

        // Address change after grant must not reach memory
        @(negedge clk);
        p1_we = 0; p1_addr = 8'h10;
        mq.push_back(mx(1'b0, 8'h10, 2'd0, 32'h0));
        dq.push_back(dx(1'b1, line_for(8'h10)));
        p1_req = 1;
        @(posedge clk);
        #1 p1_addr = 8'h20;
        wait_done(1, tmp);
        chk("stable_addr_hold", LW'(mem_addr), LW'(8'h10));
        p1_req = 0;

        // Reset during the first WAIT cycle of a port 0 read, then re-issue
        @(negedge clk);
        p0_addr = 8'h44;
        mq.push_back(mx(1'b0, 8'h44, 2'd0, 32'h0));
        p0_req = 1;
        rc = 0;
        for (int n = 0; n < 10 && rc == 0; n++) begin
            @(negedge clk);
            if (mem_r_req) rc = 1;
        end
        if (rc == 0) fail("reset_test_no_issue");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wait_reset_outputs", LW'({p0_done, p1_done, busy, mem_r_req, mem_w_req, mem_wr_en,
                                       mem_addr, mem_wid, mem_wdata}), LW'(0));
        chk("wait_reset_rdata", resp_rdata, LW'(0));
        reset = 1'b0;
        mq.push_back(mx(1'b0, 8'h44, 2'd0, 32'h0));
        dq.push_back(dx(1'b0, line_for(8'h44)));
        wait_done(0, tmp);
        p0_req = 0;

        // MEM_LAT=3 instance: port 1 read at 8'hFF
        @(negedge clk);
        p1_addr3 = 8'hFF; p1_req3 = 1;
        rc = -1; dc = -1; nreq = 0;
        for (int n = 0; n < 30 && dc < 0; n++) begin
            @(negedge clk);
            if (mem_r_req3 || mem_w_req3) begin
                rc = cyc; nreq++;
                chk("lat3_mem_addr", LW'(mem_addr3), LW'(8'hFF));
                chk("lat3_read_op", LW'({mem_w_req3, mem_wr_en3}), LW'(0));
            end
            if (p0_done3) fail("lat3_wrong_port");
            if (p1_done3) begin
                dc = cyc;
                p1_req3 = 0;
                chk("lat3_rdata", resp_rdata3, line_for(8'hFF));
            end
        end
        p1_req3 = 0;
        if (dc < 0) fail("lat3_timeout");
        else chk("lat3_latency", LW'(dc - rc), LW'(4));
        chk("lat3_single_req", LW'(nreq), LW'(1));

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", LW'(dq.size() + mq.size()), LW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
